adder_rr_arbiter: RTL

Shares one combinational W-bit `adder` instance between N requesters in the MHA datapath, such as per-head partial-sum units, using round-robin arbitration. Each requester offers an operand pair through a valid/ready handshake. The winning pair is added, and the W+1-bit sum is registered into a single-entry output stage, tagged with the winner's index. The output stage has valid/ready backpressure toward the consumer.

---
 rtl/adder_rr_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one combinational adder between N requesters,
// with a single-entry registered result stage tagged by the winner's index.

module adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] I_IN1,
    input  logic [W-1:0] I_IN2,
    output logic [W:0]   O_OUT
);
    assign O_OUT = {1'b0, I_IN1} + {1'b0, I_IN2};
endmodule

module adder_rr_arbiter #(
    parameter int W   = 16,
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             I_CLK,
    input  logic             I_RST_N,
    input  logic [N-1:0]     I_REQ_VLD,
    input  logic [N*W-1:0]   I_REQ_IN1,
    input  logic [N*W-1:0]   I_REQ_IN2,
    output logic [N-1:0]     O_REQ_RDY,
    output logic             O_RES_VLD,
    output logic [W:0]       O_RES,
    output logic [IDW-1:0]   O_RES_ID,
    input  logic             I_RES_RDY
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [W:0]     res_q, res_d;
    logic           res_vld_q, res_vld_d;

    logic           free;
    logic           gnt_any;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic [IDW:0]   scan;
    logic [IDW-1:0] idx;
    logic [W-1:0]   op1, op2;
    logic [W:0]     sum;

    // Scan from ptr upward with wrap; the first valid requester wins.
    // Reset gates the grant so nothing is offered while held in reset.
    always_comb begin
        free    = !res_vld_q || I_RES_RDY;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        scan    = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(N)) begin
                scan = scan - (IDW+1)'(N);
            end
            idx = scan[IDW-1:0];
            if (!gnt_any && free && I_RST_N && I_REQ_VLD[idx]) begin
                gnt_any     = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = idx;
            end
        end
    end

    assign op1 = I_REQ_IN1[gnt_id*W +: W];
    assign op2 = I_REQ_IN2[gnt_id*W +: W];

    adder #(.W(W)) u_adder (
        .I_IN1 (op1),
        .I_IN2 (op2),
        .O_OUT (sum)
    );

    always_comb begin
        ptr_d     = ptr_q;
        res_d     = res_q;
        res_id_d  = res_id_q;
        res_vld_d = res_vld_q;
        if (gnt_any) begin
            ptr_d     = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;
            res_d     = sum;
            res_id_d  = gnt_id;
            res_vld_d = 1'b1;
        end else if (I_RES_RDY) begin
            res_vld_d = 1'b0;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            ptr_q     <= '0;
            res_q     <= '0;
            res_id_q  <= '0;
            res_vld_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            res_q     <= res_d;
            res_id_q  <= res_id_d;
            res_vld_q <= res_vld_d;
        end
    end

    assign O_REQ_RDY = gnt;
    assign O_RES_VLD = res_vld_q;
    assign O_RES     = res_q;
    assign O_RES_ID  = res_id_q;

endmodule
